// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first, valid/ready on both sides.
// Optional build macro SERIAL_SUB_SAT_EN clamps diff to zero when the final borrow is set.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand set
// RUN   | one difference bit per cycle, counter walks 0..WIDTH-1
// DONE  | out_valid high, result held until out_ready
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] diff_final;
  logic [31:0]      cnt_ext;
  logic             cnt_bad;

  always_comb begin
    a_bit    = a_sh[0];
    b_bit    = b_sh[0];
    d_bit    = a_bit ^ b_bit ^ br;
    br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    res_next = {d_bit, res_sh};
    cnt_ext  = 32'(cnt);
    cnt_bad  = (cnt_ext > 32'(WIDTH - 1));
  end

`ifdef SERIAL_SUB_SAT_EN
  assign diff_final = br_next ? '0 : res_next;
`else
  assign diff_final = res_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      br        <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!in_ready) begin
            in_ready <= 1'b1;
          end else if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            br       <= bin;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // A corrupted counter abandons the operation rather than running forever.
          if (cnt_bad) begin
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            br     <= br_next;
            res_sh <= res_next[WIDTH-1:1];
            cnt    <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              diff      <= diff_final;
              bout      <= br_next;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor at WIDTH=8; honours SERIAL_SUB_SAT_EN.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

`ifdef SERIAL_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .bin(bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff(diff),
    .bout(bout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Counts edges from the accept edge until out_valid is seen.
  task automatic wait_done(input string tag);
    int n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(WIDTH));
  endtask

  task automatic do_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                       input logic vbin, input logic [7:0] exp_diff, input logic exp_bout);
    wait_in_ready(tag);
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 8'hA5; b = 8'h5A; bin = 1'b1;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(tag);
    chk({tag, "_diff"}, 32'(diff), 32'(exp_diff));
    chk({tag, "_bout"}, 32'(bout), 32'(exp_bout));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  logic [8:0] full;
  logic [7:0] ra, rb, held_diff;
  logic       rbin, held_bout;

  initial begin
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    do_op("t1", 8'h4A, 8'h53, 1'b0, SAT ? 8'h00 : 8'hF7, 1'b1);
    do_op("t2", 8'h53, 8'h4A, 1'b1, 8'h08, 1'b0);
    do_op("t3", 8'hFF, 8'hFF, 1'b1, SAT ? 8'h00 : 8'hFF, 1'b1);
    do_op("t4", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    // Back-pressure with a competing operand held on the input.
    wait_in_ready("bp");
    a = 8'h53; b = 8'h4A; bin = 1'b1; in_valid = 1'b1;
    tick();
    a = 8'h10; b = 8'h01; bin = 1'b0;
    wait_done("bp");
    held_diff = diff;
    held_bout = bout;
    chk("bp_diff", 32'(diff), 32'h08);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_ov_hold", 32'(out_valid), 32'd1);
      chk("bp_diff_hold", 32'(diff), 32'(held_diff));
      chk("bp_bout_hold", 32'(bout), 32'(held_bout));
      chk("bp_in_ready_lo", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_ov_clr", 32'(out_valid), 32'd0);
    chk("bp_in_ready_hi", 32'(in_ready), 32'd1);
    chk("bp_not_busy", 32'(busy), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("bp2_busy", 32'(busy), 32'd1);
    wait_done("bp2");
    chk("bp2_diff", 32'(diff), 32'h0F);
    chk("bp2_bout", 32'(bout), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during RUN, with a nonzero previous result on diff.
    wait_in_ready("ra");
    a = 8'h4A; b = 8'h53; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("ra_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ra_busy", 32'(busy), 32'd0);
    chk("ra_out_valid", 32'(out_valid), 32'd0);
    chk("ra_diff", 32'(diff), 32'd0);
    chk("ra_bout", 32'(bout), 32'd0);
    chk("ra_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_op("ra_fresh", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);

    for (int k = 0; k < 24; k++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      full = {1'b0, ra} - {1'b0, rb} - {8'b0, rbin};
      do_op("rnd", ra, rb, rbin, (SAT && full[8]) ? 8'h00 : full[7:0], full[8]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor with borrow-in that computes `diff = a - b - bin` one bit per clock, LSB first. It is the inverse-operation companion to the team's combinational adder-with-carry-in. It sits on a shared datapath where area matters more than latency. Operands are accepted and results delivered through valid/ready handshakes, so it can sit between pipeline stages without extra glue.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2 to 32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: operand set (`a`, `b`, `bin`) is valid.
- `in_ready` output 1: the block can accept operands; high only in IDLE.
- `a` input WIDTH: minuend.
- `b` input WIDTH: subtrahend.
- `bin` input 1: borrow-in.
- `out_valid` output 1: `diff` and `bout` hold a completed result.
- `out_ready` input 1: the consumer accepts the result.
- `diff` output WIDTH: difference, modulo 2^WIDTH (or saturated, see Configuration).
- `bout` output 1: borrow-out; 1 when `a < b + bin` as unsigned values.
- `busy` output 1: high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`, latch `a`, `b` and `bin` into shift registers, set the borrow register to `bin`, clear the bit counter, and go to RUN.
- RUN, one bit per cycle, with i = counter value:
  - `d_i = a_i ^ b_i ^ br`
  - `br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)`
  - Shift `d_i` into the result register from the MSB side.
  - When the counter reaches WIDTH-1, go to DONE.
- DONE:
  - `out_valid` = 1; `diff` and `bout` stay stable until the handshake.
  - On `out_valid && out_ready`, go to IDLE.
- Input operand ports are ignored outside IDLE. `in_valid` asserted while busy is simply not accepted; no error is raised.
- `diff` and `bout` keep their last value in IDLE. They update only when DONE is entered.
- The counter is ceil(log2(WIDTH)) bits wide and does not wrap in normal operation. Any out-of-range counter value forces a return to IDLE.

## Timing
- Reset values: `in_ready`=0 while `rst_n`=0, then 1 after release; `out_valid`=0; `busy`=0; `diff`=0; `bout`=0. FSM resets to IDLE.
- Latency: an operand accepted at edge T0 produces `out_valid`=1 after edge T0+WIDTH (8 cycles at the default width).
- Throughput: at most one operation per WIDTH+2 cycles when `out_ready` is held high. There is no DONE-to-accept bypass: `in_ready` rises the cycle after the result handshake.
- Back-pressure: `out_ready` low holds DONE indefinitely, with `in_ready`=0.
- Simultaneous `in_valid` and `out_ready` in DONE: only the output handshake completes. The new operand is accepted no earlier than the next cycle.
- Reset mid-operation: asserting `rst_n` low in RUN or DONE aborts immediately. All outputs return to their reset values and the result is lost.

## Configuration
- `SERIAL_SUB_SAT_EN` defined: when the final borrow is 1, `diff` is forced to 0 on entry to DONE. `bout` still reports 1.
- Undefined (default): `diff` is the raw modulo-2^WIDTH result, and `bout` reports underflow.

## Test plan
- Reset release, then WIDTH=8, a=0x4A, b=0x53, bin=0, `out_ready`=1 -> `out_valid` 8 cycles after accept, `diff`=0xF7, `bout`=1. With `SERIAL_SUB_SAT_EN`: `diff`=0x00, `bout`=1.
- a=0x53, b=0x4A, bin=1 -> `diff`=0x08, `bout`=0, in both configurations.
- a=0xFF, b=0xFF, bin=1 -> `diff`=0xFF, `bout`=1 (0x00 with saturation). a=0x00, b=0x00, bin=0 -> `diff`=0x00, `bout`=0.
- Hold `out_ready`=0 for 20 cycles after DONE, with `in_valid`=1 and new operands present throughout:
  - `out_valid`, `diff` and `bout` stay stable; `in_ready`=0; the new operands are not accepted.
  - After `out_ready` pulses, `in_ready` rises on the next cycle and the second operation completes correctly.
- Drive `rst_n` low at cycle 4 of RUN -> `busy`, `out_valid`, `diff` and `bout` read 0 immediately. After release, a fresh 0x10-0x01-0 gives `diff`=0x0F, `bout`=0.
- Randomized back-to-back operations against a reference model computing `a-b-bin` -> all results match, with no lost or duplicated handshakes.
